pipe_adder: RTL and testbench

Parametrised, pipelined successor to the 4-bit ripple-carry full adder. It adds or subtracts two WIDTH-bit operands through STAGES register stages of WIDTH/STAGES bits each, and accepts one operation per cycle. A valid/ready handshake provides backpressure. The block sits between an operand source and a result consumer in datapath designs that need full-width arithmetic at a higher clock rate than a single ripple chain allows.

---
 rtl/pipe_adder_if.sv | 28 ++
 rtl/pipe_adder.sv | 112 +++++++++++
 tb/tb_pipe_adder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_adder_if.sv
// Handshake bundle for pipe_adder: operand side (in_*) and result side (out_*).
interface pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  // Operand source and result consumer side.
  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, overflow
  );
endinterface

// File: rtl/pipe_adder.sv
// Pipelined add/subtract: STAGES register stages, each rippling one CW-bit
// chunk. Operands travel with the carry (skew) and finished low chunks
// travel with them (de-skew), so the whole result leaves the last stage at
// once. A single global advance signal stalls every stage together.
module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  pipe_adder_if.slave  bus
);
  localparam int CW = WIDTH / STAGES;

  // Registered per-stage state, exposed so stage k+1 can read stage k.
  logic [WIDTH-1:0] a_pipe     [STAGES];
  logic [WIDTH-1:0] bx_pipe    [STAGES];
  logic [WIDTH-1:0] sum_pipe   [STAGES];
  logic             carry_pipe [STAGES];
  logic             valid_pipe [STAGES];
  logic             ov_last;
  logic             out_valid_w;
  logic             advance;

  assign out_valid_w = valid_pipe[STAGES-1];
  // The pipeline moves as a whole unless a finished result is being held.
  assign advance     = !out_valid_w || bus.out_ready;

  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid_w;
  assign bus.sum       = sum_pipe[STAGES-1];
  assign bus.c_out     = carry_pipe[STAGES-1];
  assign bus.overflow  = ov_last;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] bx_in;
    logic [WIDTH-1:0] s_in;
    logic             cy_in;
    logic             v_in;
    logic [CW:0]      chunk;
    logic [WIDTH-1:0] s_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] bx_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             valid_reg;

    if (gi == 0) begin : g_first
      // Subtraction is a + ~b + 1; the forced carry-in replaces c_in.
      assign a_in  = bus.a;
      assign bx_in = bus.sub ? ~bus.b : bus.b;
      assign s_in  = '0;
      assign cy_in = bus.sub | bus.c_in;
      assign v_in  = bus.in_valid;
    end else begin : g_next
      assign a_in  = a_pipe[gi-1];
      assign bx_in = bx_pipe[gi-1];
      assign s_in  = sum_pipe[gi-1];
      assign cy_in = carry_pipe[gi-1];
      assign v_in  = valid_pipe[gi-1];
    end

    assign chunk = {1'b0, a_in[gi*CW +: CW]} + {1'b0, bx_in[gi*CW +: CW]}
                 + (CW+1)'(cy_in);

    // Merge this stage's chunk into the partially built sum.
    always_comb begin
      s_next               = s_in;
      s_next[gi*CW +: CW]  = chunk[CW-1:0];
    end

    // Stage register: loads only on advance, valid clears asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_reg <= 1'b0;
        carry_reg <= 1'b0;
        sum_reg   <= '0;
        a_reg     <= '0;
        bx_reg    <= '0;
      end else if (advance) begin
        valid_reg <= v_in;
        carry_reg <= chunk[CW];
        sum_reg   <= s_next;
        a_reg     <= a_in;
        bx_reg    <= bx_in;
      end
    end

    assign a_pipe[gi]     = a_reg;
    assign bx_pipe[gi]    = bx_reg;
    assign sum_pipe[gi]   = sum_reg;
    assign carry_pipe[gi] = carry_reg;
    assign valid_pipe[gi] = valid_reg;

    if (gi == STAGES - 1) begin : g_last
      logic ov_reg;

      // Signed overflow: operands agree in sign but the result does not.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ov_reg <= 1'b0;
        end else if (advance) begin
          ov_reg <= (a_in[WIDTH-1] == bx_in[WIDTH-1]) &&
                    (s_next[WIDTH-1] != a_in[WIDTH-1]);
        end
      end

      assign ov_last = ov_reg;
    end
  end
endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: directed literals, random streams with
// bubbles and backpressure, mid-stream reset, and a parameter sweep.
module tb_pipe_adder;
  logic clk = 1'b0;
  logic rst_n;
  logic sw_rst_n;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_txn = 0;
  int   sw_done_cnt = 0;

  always #5 clk = ~clk;

  pipe_adder_if #(.WIDTH(16)) bus ();
  pipe_adder #(.WIDTH(16), .STAGES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Expected results, {overflow, c_out, sum}, in acceptance order.
  logic [17:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference arithmetic straight from the operation definition.
  function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
    logic [15:0] bp;
    logic [16:0] ext;
    logic        ov;
    bp  = sub ? ~b : b;
    ext = {1'b0, a} + {1'b0, bp} + 17'(sub | cin);
    ov  = (a[15] == bp[15]) && (ext[15] != a[15]);
    return {ov, ext[16], ext[15:0]};
  endfunction

  // Monitor: scoreboard on handshakes, stall stability, in_ready rule.
  logic        stall_prev = 1'b0;
  logic [17:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      check("in_ready_rule", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
      if (stall_prev) begin
        check("stall_valid", 64'(bus.out_valid), 64'd1);
        check("stall_hold", 64'({bus.overflow, bus.c_out, bus.sum}), 64'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("stale_result", 64'({bus.overflow, bus.c_out, bus.sum}), 64'h3ffff_dead);
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          n_txn++;
          $display("txn %0d: sum=%h c_out=%0b ov=%0b", n_txn, bus.sum, bus.c_out, bus.overflow);
          check("scoreboard", 64'({bus.overflow, bus.c_out, bus.sum}), 64'(e));
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model16(bus.a, bus.b, bus.c_in, bus.sub));
      stall_prev = bus.out_valid && !bus.out_ready;
      held       = {bus.overflow, bus.c_out, bus.sum};
    end
  end

  task automatic drive_op(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub);
    bus.a = a; bus.b = b; bus.c_in = cin; bus.sub = sub; bus.in_valid = 1'b1;
  endtask

  // Single operation on an idle pipe: check latency and literal result.
  task automatic directed(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub, input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drive_op(a, b, cin, sub);
    @(posedge clk);
    lat = 1;
    #1 bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'd4);
    check("directed", 64'({bus.sum, bus.c_out, bus.overflow}), 64'({es, ec, eo}));
  endtask

  // Parameter sweep instances with their own reset.
  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    localparam int W = (gi == 0) ? 8 : (gi == 1) ? 32 : 4;
    localparam int S = (gi == 0) ? 1 : (gi == 1) ? 8 : 4;
    pipe_adder_if #(.WIDTH(W)) sif ();
    pipe_adder #(.WIDTH(W), .STAGES(S)) sdut (.clk(clk), .rst_n(sw_rst_n), .bus(sif));

    initial begin
      logic [W-1:0] ta, tbv, bp;
      logic [W:0]   ext;
      logic         tc, ts, eo;
      int           lat;
      sif.in_valid = 1'b0; sif.out_ready = 1'b1;
      sif.a = '0; sif.b = '0; sif.c_in = 1'b0; sif.sub = 1'b0;
      wait (sw_rst_n === 1'b1);
      for (int t = 0; t < 4; t++) begin
        ta  = W'($urandom);
        tbv = W'($urandom);
        tc  = 1'($urandom);
        ts  = (t >= 2);
        if (t == 1) begin ta = '1; tbv = '0; tc = 1'b1; end
        if (t == 3) begin ta = '0; ta[W-1] = 1'b1; tbv = W'(1); end
        bp  = ts ? ~tbv : tbv;
        ext = {1'b0, ta} + {1'b0, bp} + (W+1)'(ts | tc);
        eo  = (ta[W-1] == bp[W-1]) && (ext[W-1] != ta[W-1]);
        @(posedge clk); #1;
        sif.a = ta; sif.b = tbv; sif.c_in = tc; sif.sub = ts; sif.in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        #1 sif.in_valid = 1'b0;
        while (!sif.out_valid && lat < 40) begin
          @(posedge clk); #1;
          lat++;
        end
        check($sformatf("sweep_w%0d_latency", W), 64'(lat), 64'(S));
        check($sformatf("sweep_w%0d_result", W),
              64'({sif.overflow, sif.c_out, sif.sum}), 64'({eo, ext}));
      end
      sw_done_cnt++;
    end
  end

  initial begin
    int accepted, cyc, cnt;
    logic acc;
    rst_n = 1'b0; sw_rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a = '0; bus.b = '0; bus.c_in = 1'b0; bus.sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({bus.out_valid, bus.sum, bus.c_out, bus.overflow}), 64'd0);
    rst_n = 1'b1; sw_rst_n = 1'b1;
    #1 check("in_ready_after_reset", 64'(bus.in_ready), 64'd1);

    // Hand-computed literal cases.
    directed(16'h0003, 16'h0005, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0);
    directed(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed(16'h0002, 16'h0005, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0);
    directed(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Random stream with bubbles, no backpressure.
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      drive_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      bus.in_valid = 1'($urandom);
    end

    // Sixteen operations, in_valid held high, random backpressure.
    @(posedge clk); #1;
    drive_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    bus.out_ready = 1'($urandom);
    accepted = 0; cyc = 0;
    while (accepted < 16 && cyc < 500) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        accepted++;
        if (accepted < 16) drive_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        else bus.in_valid = 1'b0;
      end
      bus.out_ready = 1'($urandom);
    end
    check("stream_accepted", 64'(accepted), 64'd16);
    cyc = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && cyc < 300) begin
      @(posedge clk); #1;
      bus.out_ready = 1'($urandom);
      cyc++;
    end
    check("drain_complete", 64'(exp_q.size() + int'(bus.out_valid)), 64'd0);
    bus.out_ready = 1'b1;

    // Reset with a result on the output and three more in flight.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive_op(16'h1111 * 16'(i + 1), 16'h0101, 1'b0, 1'b0);
      @(posedge clk);
    end
    #1 bus.in_valid = 1'b0;
    check("pre_reset_valid", 64'(bus.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1 check("async_reset_outputs",
             64'({bus.out_valid, bus.sum, bus.c_out, bus.overflow}), 64'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    #1 check("in_ready_post_reset", 64'(bus.in_ready), 64'd1);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    check("no_stale_after_reset", 64'(cnt), 64'd0);
    directed(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);

    cyc = 0;
    while (sw_done_cnt < 3 && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    check("sweep_finished", 64'(sw_done_cnt), 64'd3);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
